// File: rtl/assert_log_pkg.sv
// Shared types, defaults and helper functions for the assertion violation logger.
// Latency: n/a (types and combinational functions only).
// Backpressure: n/a.
package assert_log_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int NUM_CHK_DEF     = 8;
  localparam int DEPTH_DEF       = 16;
  localparam int TS_W_DEF        = 32;
  localparam int CNT_W_DEF       = 16;
  localparam int STOP_ON_OVF_DEF = 0;

  // Number of set bits in a vector of up to 32 checker flags.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // a + inc, clamped to max (counters never wrap).
  function automatic logic [31:0] sat_inc(input logic [31:0] a,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/assert_log_fifo.sv
// Synchronous record FIFO with full/empty flags and a synchronous flush.
// Latency: a push is visible at the head one cycle later; pop removes the head on the edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk, rst_n (sync, active-low), clr (flush), push/wdat, pop/rdat, full, empty.
module assert_log_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this same edge, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign rdat    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdat;
  end

endmodule

// File: rtl/assert_violation_logger.sv
// Collects checker failures into counters and a record FIFO {fail mask, optional cycle stamp}.
// Latency: failure at cycle N -> counters and FIFO head updated at N+1.
// Backpressure: rec_valid/rec_ready drain; a push into a full FIFO with no pop is dropped and counted.
// Ports: clk, rst_n (sync, active-low), arm/stop/clear/dis controls, chk_fire/chk_fail inputs,
//        rec_valid/rec_ready/rec_mask/rec_ts record port, fail_cnt/drop_cnt/overflow/running status.
// Build option: ASSERT_LOG_TS_EN adds the cycle stamp counter; otherwise rec_ts is tied to 0.
module assert_violation_logger
  import assert_log_pkg::*;
#(
  parameter int NUM_CHK     = NUM_CHK_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TS_W        = TS_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STOP_ON_OVF = STOP_ON_OVF_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               stop,
  input  logic               clear,
  input  logic               dis,
  input  logic [NUM_CHK-1:0] chk_fire,
  input  logic [NUM_CHK-1:0] chk_fail,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [NUM_CHK-1:0] rec_mask,
  output logic [TS_W-1:0]    rec_ts,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               overflow,
  output logic               running
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

`ifdef ASSERT_LOG_TS_EN
  localparam int REC_W = NUM_CHK + TS_W;
`else
  localparam int REC_W = NUM_CHK;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [NUM_CHK-1:0] q;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic [REC_W-1:0]   wdat;
  logic [REC_W-1:0]   rdat;

  // A failure in the clear cycle is discarded along with everything else.
  assign q    = (state == RUN && !dis && !clear) ? (chk_fire & chk_fail) : '0;
  assign push = |q;
  assign pop  = rec_valid & rec_ready;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // stop dominates arm when both pulse together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm && !stop) state_nxt = RUN;
      RUN:     if (stop || (STOP_ON_OVF != 0 && drop)) state_nxt = STOP;
      STOP:    if (arm && !stop) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      fail_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), 32'(popcount(32'(q))), CNT_MAX));
      if (drop) begin
        drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), 32'd1, CNT_MAX));
        overflow <= 1'b1;
      end
    end
  end

`ifdef ASSERT_LOG_TS_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  assign wdat   = {q, ts};
  assign rec_ts = rec_valid ? rdat[TS_W-1:0] : '0;
`else
  assign wdat   = q;
  assign rec_ts = '0;
`endif

  assert_log_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (push),
    .wdat  (wdat),
    .pop   (pop),
    .rdat  (rdat),
    .full  (full),
    .empty (empty)
  );

  assign rec_valid = ~empty;
  // Head fields read as zero when nothing is buffered (memory is not reset).
  assign rec_mask  = rec_valid ? rdat[REC_W-1 -: NUM_CHK] : '0;

endmodule

// File: tb/tb_assert_violation_logger.sv
module tb_assert_violation_logger;

  localparam int NUM_CHK = 8;
  localparam int DEPTH   = 16;
  localparam int TS_W    = 32;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               arm, stop, clear, dis;
  logic [NUM_CHK-1:0] chk_fire, chk_fail;
  logic               rec_valid, rec_ready;
  logic [NUM_CHK-1:0] rec_mask;
  logic [TS_W-1:0]    rec_ts;
  logic [CNT_W-1:0]   fail_cnt, drop_cnt;
  logic               overflow, running;

  logic               sov_valid;
  logic [NUM_CHK-1:0] sov_mask;
  logic [TS_W-1:0]    sov_ts;
  logic [CNT_W-1:0]   sov_fail_cnt, sov_drop_cnt;
  logic               sov_overflow, sov_running;

  always #5 clk = ~clk;

  assert_violation_logger #(
    .NUM_CHK(NUM_CHK), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W), .STOP_ON_OVF(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .clear(clear), .dis(dis),
    .chk_fire(chk_fire), .chk_fail(chk_fail),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_mask(rec_mask), .rec_ts(rec_ts),
    .fail_cnt(fail_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .running(running)
  );

  assert_violation_logger #(
    .NUM_CHK(NUM_CHK), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W), .STOP_ON_OVF(1)
  ) u_dut_sov (
    .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .clear(clear), .dis(dis),
    .chk_fire(chk_fire), .chk_fail(chk_fail),
    .rec_valid(sov_valid), .rec_ready(rec_ready), .rec_mask(sov_mask), .rec_ts(sov_ts),
    .fail_cnt(sov_fail_cnt), .drop_cnt(sov_drop_cnt), .overflow(sov_overflow), .running(sov_running)
  );

  typedef struct packed {
    logic [NUM_CHK-1:0] mask;
    logic [TS_W-1:0]    ts;
  } rec_t;

  rec_t            sb[$];
  int              n_chk    = 0;
  int              n_fail   = 0;
  int              pop_cnt  = 0;
  int              exp_fail = 0;
  logic [TS_W-1:0] tb_ts;

  // Bench-side cycle count since reset release: the stamp a failure should carry.
  always @(posedge clk) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;
  end

  function automatic logic [TS_W-1:0] exp_ts(input logic [TS_W-1:0] t);
`ifdef ASSERT_LOG_TS_EN
    return t;
`else
    return '0 & t;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    return (n > 65535) ? 16'hFFFF : CNT_W'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of checker inputs; record what the bench expects to be counted/stored.
  task automatic drive_fail(input logic [NUM_CHK-1:0] fire, input logic [NUM_CHK-1:0] fail,
                            input bit counted, input bit stored);
    chk_fire = fire;
    chk_fail = fail;
    if (counted) exp_fail += $countones(fire & fail);
    if (stored)  sb.push_back({fire & fail, exp_ts(tb_ts)});
    step();
    chk_fire = '0;
    chk_fail = '0;
  endtask

  task automatic drain(input string name);
    rec_ready = 1'b1;
    for (int k = 0; k < 300 && sb.size() != 0; k++) step();
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops expected records whenever the DUT hands one over.
  logic               prev_v = 1'b0, prev_r = 1'b0;
  logic [NUM_CHK-1:0] prev_mask = '0;
  logic [TS_W-1:0]    prev_ts = '0;

  always @(negedge clk) begin
    rec_t e;
    if (rst_n && prev_v && !prev_r && rec_valid) begin
      check("hold_mask", 64'(rec_mask), 64'(prev_mask));
      check("hold_ts", 64'(rec_ts), 64'(prev_ts));
    end
    if (rst_n && rec_valid && rec_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got mask 0x%0h ts %0d, expected none", rec_mask, rec_ts);
      end else begin
        e = sb.pop_front();
        n_chk--;
        check("rec_mask", 64'(rec_mask), 64'(e.mask));
        check("rec_ts", 64'(rec_ts), 64'(e.ts));
        pop_cnt++;
      end
    end
    prev_v    = rst_n & rec_valid;
    prev_r    = rec_ready;
    prev_mask = rec_mask;
    prev_ts   = rec_ts;
  end

  initial begin
    int base;
    rst_n = 1'b0; arm = 1'b0; stop = 1'b0; clear = 1'b0; dis = 1'b0;
    chk_fire = '0; chk_fail = '0; rec_ready = 1'b1;
    repeat (3) step();

    check("rst_rec_valid", 64'(rec_valid), 64'd0);
    check("rst_rec_mask", 64'(rec_mask), 64'd0);
    check("rst_rec_ts", 64'(rec_ts), 64'd0);
    check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_running", 64'(running), 64'd0);

    rst_n = 1'b1;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_running", 64'(running), 64'd1);

    // Single failure at cycle 10.
    for (int k = 0; k < 20 && tb_ts != 32'd10; k++) step();
    sb.push_back({8'h05, exp_ts(32'd10)});
    drive_fail(8'hFF, 8'h05, 1, 0);
    check("first_rec_valid", 64'(rec_valid), 64'd1);
    check("first_fail_cnt", 64'(fail_cnt), 64'd2);
    step();

    // Disabled and unfired failures are ignored.
    dis = 1'b1;
    drive_fail(8'hFF, 8'hFF, 0, 0);
    dis = 1'b0;
    check("dis_fail_cnt", 64'(fail_cnt), 64'd2);
    drive_fail(8'h00, 8'hFF, 0, 0);
    check("nofire_fail_cnt", 64'(fail_cnt), 64'd2);
    check("nofire_no_rec", 64'(rec_valid), 64'd0);

    // 17 failing cycles into a 16-deep FIFO with no drain.
    rec_ready = 1'b0;
    for (int i = 0; i < 17; i++) drive_fail(8'hFF, 8'(i + 1), 1, i < 16);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    check("ovf_overflow", 64'(overflow), 64'd1);
    check("ovf_running", 64'(running), 64'd1);
    check("ovf_sov_running", 64'(sov_running), 64'd0);
    check("ovf_fail_cnt", 64'(fail_cnt), 64'd37);

    // Full FIFO: push and pop in the same cycle.
    rec_ready = 1'b1;
    drive_fail(8'hFF, 8'hAA, 1, 1);
    rec_ready = 1'b0;
    base = pop_cnt;
    check("fullpp_drop_cnt", 64'(drop_cnt), 64'd1);
    check("fullpp_fail_cnt", 64'(fail_cnt), 64'd41);
    step();
    drain("fullpp_drain");
    check("fullpp_occupancy", 64'(pop_cnt - base), 64'd16);
    check("fullpp_empty", 64'(rec_valid), 64'd0);

    // Drive the fail counter into saturation.
    rec_ready = 1'b1;
    for (int i = 0; i < 8192; i++) drive_fail(8'hFF, 8'hFF, 1, 1);
    check("sat_fail_cnt", 64'(fail_cnt), 64'(exp_cnt(exp_fail)));
    check("sat_fail_cnt_max", 64'(fail_cnt), 64'hFFFF);
    drain("sat_drain");
    check("sat_drop_cnt", 64'(drop_cnt), 64'd1);

    // clear empties FIFO, zeroes counters, ignores its own-cycle failure.
    check("pre_clear_overflow", 64'(overflow), 64'd1);
    rec_ready = 1'b0;
    drive_fail(8'hFF, 8'h01, 0, 0);
    drive_fail(8'hFF, 8'h02, 0, 0);
    clear = 1'b1;
    drive_fail(8'hFF, 8'hFF, 0, 0);
    clear = 1'b0;
    exp_fail = 0;
    check("clr_fail_cnt", 64'(fail_cnt), 64'd0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_rec_valid", 64'(rec_valid), 64'd0);
    check("clr_running", 64'(running), 64'd1);
    rec_ready = 1'b1;

    // STOP handling and arm/stop priority.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_running", 64'(running), 64'd0);
    drive_fail(8'hFF, 8'hFF, 0, 0);
    check("stop_fail_cnt", 64'(fail_cnt), 64'd0);
    arm = 1'b1; stop = 1'b1;
    step();
    arm = 1'b0; stop = 1'b0;
    check("armstop_running", 64'(running), 64'd0);
    arm = 1'b1;
    drive_fail(8'hFF, 8'hFF, 0, 0);
    arm = 1'b0;
    check("rearm_running", 64'(running), 64'd1);
    check("rearm_fail_cnt", 64'(fail_cnt), 64'd0);
    check("rearm_no_rec", 64'(rec_valid), 64'd0);

    // Reset in the middle of a drain.
    rec_ready = 1'b0;
    drive_fail(8'hFF, 8'h11, 1, 1);
    drive_fail(8'hFF, 8'h22, 1, 0);
    drive_fail(8'hFF, 8'h33, 1, 0);
    rec_ready = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    check("midrst_rec_valid", 64'(rec_valid), 64'd0);
    check("midrst_running", 64'(running), 64'd0);
    check("midrst_fail_cnt", 64'(fail_cnt), 64'd0);
    sb.delete();
    exp_fail = 0;
    rst_n = 1'b1;
    step();

    // Stamp restarts after reset.
    arm = 1'b1;
    step();
    arm = 1'b0;
    drive_fail(8'h0F, 8'h3C, 1, 1);
    check("post_rst_fail_cnt", 64'(fail_cnt), 64'd2);
    drain("post_rst_drain");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/assert_violation_logger.md
# assert_violation_logger

Downstream collector for the assertion/checker layer. Each cycle it samples up to NUM_CHK checker evaluation strobes and their failure flags, keeps total and dropped-record counts, and buffers one violation record per failing cycle (failure mask plus optional cycle timestamp) in a small FIFO. A bench or debug port drains the FIFO over a valid/ready interface.

## Interface
- NUM_CHK, 8, number of checker inputs (1..32)
- DEPTH, 16, record FIFO depth (power of two, ≥2)
- TS_W, 32, timestamp width
- CNT_W, 16, width of fail_cnt and drop_cnt
- STOP_ON_OVF, 0, 1 = FSM enters STOP on first dropped record

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- arm  in  1  pulse; IDLE/STOP → RUN
- stop  in  1  pulse; RUN → STOP
- clear  in  1  pulse; empties FIFO, zeroes counters and overflow
- dis  in  1  disable-iff equivalent; while 1, failures are ignored
- chk_fire  in  NUM_CHK  checker i evaluated this cycle
- chk_fail  in  NUM_CHK  checker i failed (qualified by chk_fire[i])
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_mask  out  NUM_CHK  failing checkers of head record
- rec_ts  out  TS_W  cycle stamp of head record
- fail_cnt  out  CNT_W  total qualified failures, saturating
- drop_cnt  out  CNT_W  records lost to full FIFO, saturating
- overflow  out  1  sticky, set on first drop
- running  out  1  1 in RUN

## Operation
- Qualified fail vector q = chk_fire & chk_fail, forced to 0 when dis=1 or state≠RUN.
- FSM: IDLE (reset state) → RUN on arm; RUN → STOP on stop, or on first drop when STOP_ON_OVF=1; STOP → RUN on arm. arm and stop in the same cycle: stop wins.
- In RUN with q≠0: fail_cnt += popcount(q), saturating at 2^CNT_W−1; push record {q, ts}.
- Push while FIFO full and no pop in the same cycle: record discarded, drop_cnt +1 (saturating), overflow set.
- Full with a pop in the same cycle: push is accepted.
- Pop occurs when rec_valid & rec_ready. The FIFO drains in every state.
- clear: empties the FIFO, zeroes fail_cnt, drop_cnt and overflow. FSM state and ts are unchanged. A failure in the clear cycle is neither counted nor stored.
- ts: free-running counter from 0 after reset, wraps modulo 2^TS_W.

## Timing
- Reset values: rec_valid=0, rec_mask=0, rec_ts=0, fail_cnt=0, drop_cnt=0, overflow=0, running=0, state=IDLE, ts=0.
- Failure at cycle N: record carries ts=N; rec_valid=1 at N+1 if the FIFO was empty; fail_cnt reflects it at N+1.
- arm at N: running=1 at N+1. Failures at N are not logged.
- rec_mask and rec_ts stay stable while rec_valid=1 and rec_ready=0.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and FIFO contents are lost.

## Configuration
- ASSERT_LOG_TS_EN defined: the timestamp counter exists and rec_ts carries the capture cycle.
- ASSERT_LOG_TS_EN not defined: the counter and ts FIFO storage are removed, and rec_ts is tied to 0.
- Port list is identical in both builds.

## Structure
- Package assert_log_pkg:
  - state enum {IDLE, RUN, STOP}
  - saturating-increment and popcount functions
  - default parameter constants
- Sub-module assert_log_fifo: synchronous FIFO with DEPTH, a parameterised data width, and full/empty flags. It supports push and pop in the same cycle when full.

## Test plan
- Reset, arm, fail=0x05 with fire=0xFF at cycle 10 → rec_mask=0x05, rec_ts=10, fail_cnt=2, rec_valid at cycle 11.
- dis=1 with fail=0xFF → fail_cnt unchanged, no record. chk_fire=0 with chk_fail=0xFF → same.
- rec_ready=0, 17 consecutive failing cycles, DEPTH=16 → 16 records, drop_cnt=1, overflow=1. With STOP_ON_OVF=1, running=0 next cycle.
- FIFO full, push and pop in the same cycle → no drop, occupancy stays 16, order preserved.
- fail_cnt preset near saturation via 0xFFFF failures (CNT_W=16) → holds at 0xFFFF. clear → all counters 0, overflow 0, FIFO empty, state unchanged.
- Without ASSERT_LOG_TS_EN: rec_ts=0 for every record. rst_n=0 mid-drain → rec_valid=0 on the next edge.
